blink_period_meter: RTL and testbench
=====================================

# blink_period_meter

Receive-side counterpart of the blinker: samples an asynchronous 1-bit blink waveform, synchronizes and optionally deglitches it, and measures the high and low phase durations in clock cycles. Reports one high/low pair per complete blink cycle and flags a stuck line. Sits at the board input boundary, e.g. a photodiode or loopback of another board's LED, feeding period/duty checks in the top entity.

## Interface
- CNT_W, 24, width of phase counters and outputs
- TIMEOUT, 10000000, phase length in cycles that declares the line stuck; must satisfy 1 < TIMEOUT < 2^CNT_W
- FILT_LEN, 4, consecutive equal samples needed to accept a level change (filter build only); 2..15

- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous reset, active low
- input_0  in  [0:0]  raw blink waveform, asynchronous to system1000
- level_o  out  1  filtered, synchronized line level
- high_time_o  out  CNT_W  cycles of the last complete high phase
- low_time_o  out  CNT_W  cycles of the last complete low phase
- valid_o  out  1  one-cycle pulse: high_time_o/low_time_o updated as a pair
- stuck_o  out  1  line held one level for TIMEOUT cycles

## Operation
- Front end: 2-flop synchronizer on input_0 (reset 0) -> filter (see Configuration) -> filtered level L -> 1-cycle delayed copy for edge detect. level_o = L.
- Phase counter CNT: loaded with 1 on any edge of L, else increments, saturating at TIMEOUT.
- Flag HAVE_HIGH: a full high phase has been captured since the last IDLE/STUCK exit.
- States:
  - IDLE (after reset): CNT held 0; rising edge -> HIGH; falling edge -> LOW; HAVE_HIGH = 0.
  - HIGH: falling edge -> capture CNT into internal high register, HAVE_HIGH = 1, -> LOW.
  - LOW: rising edge -> if HAVE_HIGH: high_time_o <= high register, low_time_o <= CNT, valid_o = 1 next cycle; -> HIGH.
  - HIGH/LOW with CNT == TIMEOUT and no edge -> STUCK; stuck_o = 1; HAVE_HIGH = 0.
  - STUCK: rising edge -> HIGH, falling edge -> LOW, stuck_o cleared on the transition; CNT = 1.
- Captured value = exact number of cycles L held the level (edge cycle counts as 1).
- Edge on the same cycle CNT reaches TIMEOUT: edge wins, TIMEOUT is captured as a valid measurement, no STUCK.
- high_time_o/low_time_o hold last pair until the next valid_o; not cleared on STUCK.
- Reset (any time, including mid-phase): all state, filter, synchronizer and outputs to reset values immediately; no valid_o for the interrupted cycle.

## Timing
- Reset values: level_o 0, high_time_o 0, low_time_o 0, valid_o 0, stuck_o 0, state IDLE.
- input_0 -> level_o: 2 cycles (no filter), 2 + FILT_LEN cycles (filter).
- Rising edge of level_o ending a low phase -> valid_o high exactly 1 cycle later, for 1 cycle, with both time outputs valid in that same cycle.
- stuck_o asserts the cycle after CNT reaches TIMEOUT; deasserts 1 cycle after the ending edge of level_o.
- Minimum measurable phase: 1 cycle (no filter), FILT_LEN cycles (filter).

## Configuration
- BLINK_GLITCH_FILTER_EN defined: L changes only after FILT_LEN consecutive synchronized samples differ from current L; shorter pulses ignored and not counted. Filter counter resets to 0.
- Not defined: L = synchronizer output directly; FILT_LEN unused; every sampled transition is an edge.

## Test plan (TIMEOUT=100, CNT_W=8, FILT_LEN=4)
- Square wave 10 high / 20 low, 3 cycles -> first valid_o at end of first full low; high_time_o=10, low_time_o=20 each pulse; stuck_o 0.
- Start mid-low, then 7 high / 5 low -> no valid_o for the initial partial low; next pulses report 7/5.
- Hold input_0 high 150 cycles after a rising edge -> stuck_o rises 1 cycle after CNT=100; times unchanged; falling edge clears stuck_o, next full cycle reports fresh pair.
- Phase of exactly 100 cycles ending in an edge -> captured 100, valid_o later, stuck_o stays 0.
- Filter build: 2-cycle low glitch inside a 30-cycle high -> high_time_o=30, no extra valid_o; no-filter build: glitch splits phase, reported high=… first segment length, low=2.
- Assert system1000_rstn low mid-high phase -> all outputs 0 asynchronously; after release, first valid_o only after a new complete high+low.

Source files
------------

// File: rtl/blink_period_meter.sv
// -----------------------------------------------------------------------------
// blink_period_meter
//
// Receive-side counterpart of the blinker. Samples an asynchronous 1-bit blink
// waveform, synchronizes it (and optionally deglitches it), then measures the
// high and low phase durations in clock cycles. One high/low pair is reported
// per complete blink cycle, and a line held at one level for TIMEOUT cycles is
// flagged as stuck.
//
// Optional feature macro: BLINK_GLITCH_FILTER_EN
//   defined   : a level change is accepted only after FILT_LEN consecutive
//               synchronized samples disagree with the current level.
//   undefined : the synchronizer output is used directly.
//
// Parameters
//   CNT_W    width of the phase counter and the time outputs
//   TIMEOUT  phase length (cycles) that declares the line stuck, 1 < TIMEOUT < 2^CNT_W
//   FILT_LEN consecutive equal samples needed to accept a level change (2..15)
//
// Ports
//   system1000       in   clock
//   system1000_rstn  in   asynchronous reset, active low
//   input_0          in   raw blink waveform, asynchronous to system1000
//   level_o          out  filtered, synchronized line level
//   high_time_o      out  cycles of the last complete high phase
//   low_time_o       out  cycles of the last complete low phase
//   valid_o          out  one-cycle pulse: both time outputs updated as a pair
//   stuck_o          out  line held one level for TIMEOUT cycles
// -----------------------------------------------------------------------------
module blink_period_meter #(
  parameter int CNT_W    = 24,
  parameter int TIMEOUT  = 10000000,
  parameter int FILT_LEN = 4
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic [0:0]       input_0,
  output logic             level_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic [CNT_W-1:0] low_time_o,
  output logic             valid_o,
  output logic             stuck_o
);

  // Elaboration-time parameter sanity checks.
  if (TIMEOUT <= 1 || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
    $error("blink_period_meter: TIMEOUT out of range for CNT_W");
  end
  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("blink_period_meter: FILT_LEN must be 2..15");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_STUCK
  } state_e;

  // Phase counter increment, saturating at TIMEOUT.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= TIMEOUT_C) begin
      sat_inc = TIMEOUT_C;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Front end: two-flop synchronizer
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= input_0[0];
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional glitch filter producing the accepted level
  // ---------------------------------------------------------------------------
  logic lvl;

`ifdef BLINK_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic       lvl_q;
  logic       lvl_d;
  logic [3:0] filt_cnt_q;
  logic [3:0] filt_cnt_d;

  // The counter tracks how many consecutive samples have disagreed with the
  // accepted level; any agreeing sample discards the partial run, so pulses
  // shorter than FILT_LEN never reach the measurement logic.
  always_comb begin
    lvl_d      = lvl_q;
    filt_cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        lvl_d = sync2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      lvl_q      <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      lvl_q      <= lvl_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync2_q;
`endif

  // ---------------------------------------------------------------------------
  // Edge detect on the accepted level
  // ---------------------------------------------------------------------------
  logic lvl_dly_q;
  logic rise;
  logic fall;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      lvl_dly_q <= 1'b0;
    end else begin
      lvl_dly_q <= lvl;
    end
  end

  assign rise = lvl & ~lvl_dly_q;
  assign fall = ~lvl & lvl_dly_q;

  // ---------------------------------------------------------------------------
  // Measurement FSM, phase counter and result registers
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             have_high_q, have_high_d;
  logic [CNT_W-1:0] high_cap_q,  high_cap_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W-1:0] low_time_q,  low_time_d;
  logic             valid_q,     valid_d;

  // The counter is loaded with 1 on the edge cycle, so on the cycle of the
  // next edge it holds exactly the number of cycles the level was held.
  always_comb begin
    state_d     = state_q;
    cnt_d       = sat_inc(cnt_q);
    have_high_d = have_high_q;
    high_cap_d  = high_cap_q;
    high_time_d = high_time_q;
    low_time_d  = low_time_q;
    valid_d     = 1'b0;

    if (rise || fall) begin
      cnt_d = CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        have_high_d = 1'b0;
        if (rise) begin
          state_d = S_HIGH;
        end else if (fall) begin
          state_d = S_LOW;
        end else begin
          cnt_d = '0;
        end
      end

      S_HIGH: begin
        // An edge on the cycle the counter reaches TIMEOUT takes priority,
        // so a phase of exactly TIMEOUT cycles is still a valid measurement.
        if (fall) begin
          high_cap_d  = cnt_q;
          have_high_d = 1'b1;
          state_d     = S_LOW;
        end else if (cnt_q == TIMEOUT_C) begin
          have_high_d = 1'b0;
          state_d     = S_STUCK;
        end
      end

      S_LOW: begin
        if (rise) begin
          // Only a low phase preceded by a fully captured high phase
          // completes a reportable pair.
          if (have_high_q) begin
            high_time_d = high_cap_q;
            low_time_d  = cnt_q;
            valid_d     = 1'b1;
          end
          state_d = S_HIGH;
        end else if (cnt_q == TIMEOUT_C) begin
          have_high_d = 1'b0;
          state_d     = S_STUCK;
        end
      end

      S_STUCK: begin
        have_high_d = 1'b0;
        if (rise) begin
          state_d = S_HIGH;
        end else if (fall) begin
          state_d = S_LOW;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      have_high_q <= 1'b0;
      high_cap_q  <= '0;
      high_time_q <= '0;
      low_time_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      have_high_q <= have_high_d;
      high_cap_q  <= high_cap_d;
      high_time_q <= high_time_d;
      low_time_q  <= low_time_d;
      valid_q     <= valid_d;
    end
  end

  assign level_o     = lvl;
  assign high_time_o = high_time_q;
  assign low_time_o  = low_time_q;
  assign valid_o     = valid_q;
  assign stuck_o     = (state_q == S_STUCK);

endmodule

// File: tb/tb_blink_period_meter.sv
// -----------------------------------------------------------------------------
// tb_blink_period_meter
//
// Drives directed and random blink waveforms into blink_period_meter
// (CNT_W=8, TIMEOUT=100, FILT_LEN=4) and compares every output on every cycle
// against a phase-length reference model: the accepted level is the input
// delayed by the synchronizer (and filtered when BLINK_GLITCH_FILTER_EN is
// defined); a pair is expected one cycle after a rising edge that ends a low
// phase preceded by a high phase, both started by an edge and no longer than
// TIMEOUT; stuck is expected while the current run has lasted past TIMEOUT.
// -----------------------------------------------------------------------------
module tb_blink_period_meter;

  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 100;
  localparam int FILT_LEN = 4;

  logic             clk;
  logic             rst_n;
  logic [0:0]       din;
  logic             level_o;
  logic [CNT_W-1:0] high_time_o;
  logic [CNT_W-1:0] low_time_o;
  logic             valid_o;
  logic             stuck_o;

  int n_chk;
  int n_err;

  blink_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .system1000     (clk),
    .system1000_rstn(rst_n),
    .input_0        (din),
    .level_o        (level_o),
    .high_time_o    (high_time_o),
    .low_time_o     (low_time_o),
    .valid_o        (valid_o),
    .stuck_o        (stuck_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, evaluated once per cycle on the falling edge
  // ---------------------------------------------------------------------------
  bit s1, s2, in_prev;
  bit lm, lm_prev;
  int fc;
  int mc;
  int run_start;
  bit run_edge;
  bit hv;
  int hlen;
  bit pend;
  int ph, pl;
  int exp_hi, exp_lo;

  always @(negedge clk) begin
    bit x, ev, es;
    int n;
    mc++;
    if (!rst_n) begin
      s1 = 0; s2 = 0; in_prev = din[0];
      lm = 0; lm_prev = 0; fc = 0;
      run_start = mc; run_edge = 0;
      hv = 0; pend = 0; exp_hi = 0; exp_lo = 0;
    end else begin
      x       = s2;
      s2      = s1;
      s1      = in_prev;
      in_prev = din[0];
`ifdef BLINK_GLITCH_FILTER_EN
      if (x != lm) begin
        fc++;
        if (fc == FILT_LEN) begin
          lm = x;
          fc = 0;
        end
      end else begin
        fc = 0;
      end
`else
      x  = 0;
      lm = s2;
`endif
      // Stuck is judged on the run in progress before this cycle's edge.
      es = run_edge && ((mc - run_start) >= TIMEOUT + 1);
      ev = pend;
      if (pend) begin
        exp_hi = ph;
        exp_lo = pl;
        pend   = 0;
      end
      if (lm != lm_prev) begin
        n = mc - run_start;
        if (lm == 1'b0) begin
          hv   = run_edge && (n <= TIMEOUT);
          hlen = n;
        end else begin
          if (hv && run_edge && n <= TIMEOUT) begin
            pend = 1;
            ph   = hlen;
            pl   = n;
          end
          hv = 0;
        end
        run_start = mc;
        run_edge  = 1;
        lm_prev   = lm;
      end
      chk("level", 32'(level_o), 32'(lm));
      chk("valid", 32'(valid_o), 32'(ev));
      chk("high_time", 32'(high_time_o), exp_hi);
      chk("low_time", 32'(low_time_o), exp_lo);
      chk("stuck", 32'(stuck_o), 32'(es));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive_phase(input bit v, input int n);
    din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(level_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_stuck", 32'(stuck_o), 0);
    chk("rst_high", 32'(high_time_o), 0);
    chk("rst_low", 32'(low_time_o), 0);
    release_reset();

    // Partial initial low, then square waves.
    drive_phase(0, 15);
    for (int i = 0; i < 3; i++) begin
      drive_phase(1, 10);
      drive_phase(0, 20);
    end
    for (int i = 0; i < 3; i++) begin
      drive_phase(1, 7);
      drive_phase(0, 5);
    end

    // Stuck high, then recovery and a fresh pair.
    drive_phase(1, 150);
    drive_phase(0, 20);
    drive_phase(1, 9);
    drive_phase(0, 11);

    // Phases of exactly TIMEOUT cycles, and one just over.
    drive_phase(1, 100);
    drive_phase(0, 30);
    drive_phase(1, 6);
    drive_phase(0, 100);
    drive_phase(1, 8);
    drive_phase(0, 101);
    drive_phase(1, 12);
    drive_phase(0, 13);

    // Short low glitch inside a high phase.
    drive_phase(1, 14);
    drive_phase(0, 2);
    drive_phase(1, 14);
    drive_phase(0, 10);

    // Reset asserted mid-high phase.
    drive_phase(1, 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level_o), 0);
    chk("arst_valid", 32'(valid_o), 0);
    chk("arst_stuck", 32'(stuck_o), 0);
    chk("arst_high", 32'(high_time_o), 0);
    chk("arst_low", 32'(low_time_o), 0);
    repeat (3) @(posedge clk);
    release_reset();
    drive_phase(1, 20);
    drive_phase(0, 15);
    drive_phase(1, 6);
    drive_phase(0, 8);

    // Random phases.
    for (int i = 0; i < 80; i++) begin
      int len;
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(95, 110);
      end else begin
        len = $urandom_range(1, 25);
      end
      drive_phase(bit'(i % 2 == 0), len);
    end
    drive_phase(0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
